// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master fair arbiter for a shared RAM port; ARB_TIMEOUT_EN adds a grant watchdog.
`ifndef WB_AddrBus
`define WB_AddrBus 31:0
`endif
`ifndef WB_DataBus
`define WB_DataBus 31:0
`endif
module ram_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`WB_AddrBus] m0_addr_i,
  input  logic [`WB_DataBus] m0_data_i,
  input  logic              m0_select_i,
  input  logic              m0_we_i,
  output logic [`WB_DataBus] m0_data_o,
  output logic              m0_ack_o,
  input  logic [`WB_AddrBus] m1_addr_i,
  input  logic [`WB_DataBus] m1_data_i,
  input  logic              m1_select_i,
  input  logic              m1_we_i,
  output logic [`WB_DataBus] m1_data_o,
  output logic              m1_ack_o,
  output logic [`WB_AddrBus] bus_addr_o,
  output logic [`WB_DataBus] bus_data_o,
  output logic              bus_select_o,
  output logic              bus_we_o,
  input  logic [`WB_DataBus] bus_data_i,
  input  logic              bus_ack_i,
  output logic [1:0]        grant_o,
  output logic              arb_timeout_o
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic last_q, last_d;
  logic g0, g1, sel, done, tmo;
  assign g0 = state_q == GRANT0;
  assign g1 = state_q == GRANT1;
  assign sel = g0 ? m0_select_i : g1 & m1_select_i;
  assign bus_select_o = sel;
  assign bus_we_o = g0 ? m0_we_i : g1 & m1_we_i;
  assign bus_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
  assign bus_data_o = g0 ? m0_data_i : g1 ? m1_data_i : '0;
  assign m0_ack_o = g0 & bus_ack_i;
  assign m1_ack_o = g1 & bus_ack_i;
  assign m0_data_o = bus_data_i;
  assign m1_data_o = bus_data_i;
  assign grant_o = grant_q;
  always_comb begin
    done = bus_ack_i | ~sel | tmo;
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (m0_select_i && (!m1_select_i || last_q)) state_d = GRANT0;
      else if (m1_select_i) state_d = GRANT1;
    end else if (done) begin
      state_d = IDLE;
      last_d = g1;
    end
    grant_d = {state_d == GRANT1, state_d == GRANT0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d;
  // Counter is zero on grant entry; the grant cycle that would reach the limit ends the grant.
  assign tmo = (g0 | g1) & sel & ~bus_ack_i & (cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES));
  always_comb begin
    cnt_d = ((g0 | g1) && !done) ? cnt_q + CW'(1) : '0;
    tmo_d = tmo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign arb_timeout_o = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
  assign arb_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of arbitration, routing, reset, abort and watchdog behaviour.
module tb_ram_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, bus_rdata = 0;
  logic m0_sel = 0, m0_we = 0, m1_sel = 0, m1_we = 0, bus_ack = 0;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic m0_ack, m1_ack, bus_sel, bus_we, tmo;
  logic [1:0] grant;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ram_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_select_i(m0_sel), .m0_we_i(m0_we),
    .m0_data_o(m0_rdata), .m0_ack_o(m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_select_i(m1_sel), .m1_we_i(m1_we),
    .m1_data_o(m1_rdata), .m1_ack_o(m1_ack),
    .bus_addr_o(bus_addr), .bus_data_o(bus_wdata), .bus_select_o(bus_sel), .bus_we_o(bus_we),
    .bus_data_i(bus_rdata), .bus_ack_i(bus_ack), .grant_o(grant), .arb_timeout_o(tmo)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_sel", {31'd0, bus_sel}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_tmo", {31'd0, tmo}, 0);
    // single m0 read
    tick();
    rst = 0; m0_sel = 1; m0_addr = 32'h100;
    tick();
    @(negedge clk);
    chk("rd_grant", {30'd0, grant}, 1);
    chk("rd_sel", {31'd0, bus_sel}, 1);
    chk("rd_addr", bus_addr, 32'h100);
    chk("rd_ack_early", {31'd0, m0_ack}, 0);
    tick();
    bus_ack = 1; bus_rdata = 32'h55AA_1234;
    @(negedge clk);
    chk("rd_ack", {31'd0, m0_ack}, 1);
    chk("rd_data", m0_rdata, 32'h55AA_1234);
    chk("rd_m1_ack", {31'd0, m1_ack}, 0);
    tick();
    m0_sel = 0; bus_ack = 0;
    @(negedge clk);
    chk("rd_idle_grant", {30'd0, grant}, 0);
    chk("rd_idle_ack", {31'd0, m0_ack}, 0);
    chk("rd_idle_sel", {31'd0, bus_sel}, 0);
    // fairness under continuous dual requests
    rst = 1;
    tick();
    rst = 0; m0_sel = 1; m1_sel = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_ack = 1;
      @(negedge clk);
      chk("fair_grant", {30'd0, grant}, (i % 2 == 0) ? 1 : 2);
      chk("fair_addr", bus_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("fair_m0_ack", {31'd0, m0_ack}, (i % 2 == 0) ? 1 : 0);
      chk("fair_m1_ack", {31'd0, m1_ack}, (i % 2 == 0) ? 0 : 1);
      tick();
      bus_ack = 0;
      @(negedge clk);
      chk("fair_turn", {30'd0, grant}, 0);
    end
    // m1 write with forwarding of changing address
    m0_sel = 0; m1_addr = 32'h2000; m1_wdata = 32'hDEADBEEF; m1_we = 1;
    tick();
    @(negedge clk);
    chk("wr_grant", {30'd0, grant}, 2);
    chk("wr_we", {31'd0, bus_we}, 1);
    chk("wr_data", bus_wdata, 32'hDEADBEEF);
    chk("wr_addr", bus_addr, 32'h2000);
    m1_addr = 32'h2004;
    #1;
    chk("wr_fwd_addr", bus_addr, 32'h2004);
    bus_ack = 1;
    #1;
    chk("wr_m1_ack", {31'd0, m1_ack}, 1);
    chk("wr_m0_ack", {31'd0, m0_ack}, 0);
    tick();
    bus_ack = 0; m1_sel = 0; m1_we = 0;
    @(negedge clk);
    chk("wr_idle_we", {31'd0, bus_we}, 0);
    chk("wr_idle_data", bus_wdata, 0);
    // reset in the middle of a grant
    m0_sel = 1; m0_addr = 32'h300;
    tick();
    @(negedge clk);
    chk("mid_grant", {30'd0, grant}, 1);
    rst = 1;
    tick();
    rst = 0; m0_sel = 0;
    @(negedge clk);
    chk("mid_rst_grant", {30'd0, grant}, 0);
    chk("mid_rst_sel", {31'd0, bus_sel}, 0);
    bus_ack = 1;
    #1;
    chk("late_ack_m0", {31'd0, m0_ack}, 0);
    chk("late_ack_m1", {31'd0, m1_ack}, 0);
    tick();
    bus_ack = 0;
    @(negedge clk);
    chk("late_ack_grant", {30'd0, grant}, 0);
    // m1 abort with m0 pending
    m1_sel = 1;
    tick();
    m0_sel = 1;
    @(negedge clk);
    chk("abort_grant", {30'd0, grant}, 2);
    m1_sel = 0;
    #1;
    chk("abort_sel", {31'd0, bus_sel}, 0);
    tick();
    @(negedge clk);
    chk("abort_idle", {30'd0, grant}, 0);
    chk("abort_no_ack", {31'd0, m1_ack}, 0);
    tick();
    @(negedge clk);
    chk("abort_m0", {30'd0, grant}, 1);
    // m0 is now granted and the RAM never acks
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("wd_hold", {30'd0, grant}, 1);
      chk("wd_quiet", {31'd0, tmo}, 0);
    end
    tick();
    @(negedge clk);
    chk("wd_pulse", {31'd0, tmo}, 1);
    chk("wd_grant", {30'd0, grant}, 0);
    chk("wd_no_ack", {31'd0, m0_ack}, 0);
    m0_sel = 0;
    tick();
    @(negedge clk);
    chk("wd_pulse_end", {31'd0, tmo}, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      @(negedge clk);
      chk("hold_grant", {30'd0, grant}, 1);
      chk("hold_tmo", {31'd0, tmo}, 0);
    end
    m0_sel = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
